// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter constants: default tag/value widths
// and the fixed requester index assignments.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ   = 3;
  localparam int CDB_ID_WIDTH  = 4;
  localparam int CDB_VAL_WIDTH = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSB = 1;
  localparam int REQ_BRU = 2;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational round-robin pick: first set cand bit at or after ptr.
// Ports: cand, ptr in; one-hot grant, encoded idx, any out.
module rr_select #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && cand[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a one-entry buffer per requester.
// Ports: clk/rst_in_n/rdy_in/flush, req_* in, req_ready, cdb_* out.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = CDB_NUM_REQ,
  parameter int ID_WIDTH  = CDB_ID_WIDTH,
  parameter int VAL_WIDTH = CDB_VAL_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_in_n,
  input  logic                           rdy_in,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ*VAL_WIDTH-1:0]   req_val,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cdb_valid,
  output logic [ID_WIDTH-1:0]            cdb_tag,
  output logic [VAL_WIDTH-1:0]           cdb_val,
  output logic [$clog2(NUM_REQ)-1:0]     cdb_src
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   hb_valid;
  logic [ID_WIDTH-1:0]  hb_tag [NUM_REQ];
  logic [VAL_WIDTH-1:0] hb_val [NUM_REQ];
  logic [PW-1:0]        rr_ptr;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   drop;
  logic [NUM_REQ-1:0]   grant;
  logic [PW-1:0]        win;
  logic [PW-1:0]        ptr_nxt;
  logic                 any;
  logic                 en;

  always_comb begin
    cand = '0;
    drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = hb_valid[i] & (hb_tag[i] != '0);
      drop[i] = hb_valid[i] & (hb_tag[i] == '0);
    end
  end

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_sel (
    .cand  (cand),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  // Tag-0 drops free their slot at the same edge, like a grant.
  assign en        = rdy_in & ~flush & rst_in_n;
  assign req_ready = {NUM_REQ{en}} & (~hb_valid | grant | drop);
  assign ptr_nxt   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      hb_valid  <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_val   <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hb_tag[i] <= '0;
        hb_val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        hb_valid  <= '0;
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            hb_valid[i] <= 1'b1;
            hb_tag[i]   <= req_tag[i*ID_WIDTH +: ID_WIDTH];
            hb_val[i]   <= req_val[i*VAL_WIDTH +: VAL_WIDTH];
          end else if (grant[i] || drop[i]) begin
            hb_valid[i] <= 1'b0;
          end
        end
        cdb_valid <= any;
        if (any) begin
          cdb_tag <= hb_tag[win];
          cdb_val <= hb_val[win];
          cdb_src <= win;
          rr_ptr  <= ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
// Inputs change #1 after posedge; outputs checked there too.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_in_n;
  logic        rdy_in;
  logic        flush;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_val;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [1:0]  cdb_src;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .rst_in_n  (rst_in_n),
    .rdy_in    (rdy_in),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_val   (req_val),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .cdb_src   (cdb_src)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // val is always tag * 0x11
  task automatic drive(input logic [2:0] v,
                       input logic [3:0] t0,
                       input logic [3:0] t1,
                       input logic [3:0] t2);
    req_valid = v;
    req_tag   = {t2, t1, t0};
    req_val   = {32'(t2) * 32'h11, 32'(t1) * 32'h11, 32'(t0) * 32'h11};
  endtask

  task automatic cdb(input string tag,
                     input logic v,
                     input logic [3:0] t,
                     input logic [1:0] s);
    chk({tag, "_v"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      chk({tag, "_tag"}, 64'(cdb_tag), 64'(t));
      chk({tag, "_val"}, 64'(cdb_val), 64'(t) * 64'h11);
      chk({tag, "_src"}, 64'(cdb_src), 64'(s));
    end
  endtask

  initial begin
    rst_in_n = 1'b0;
    rdy_in   = 1'b1;
    flush    = 1'b0;
    drive(3'b000, 0, 0, 0);
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_cdbv", 64'(cdb_valid), 64'h0);
    rst_in_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'h7);
    chk("rel_ptr", 64'(dut.rr_ptr), 64'h0);

    // single requester streaming
    drive(3'b001, 1, 0, 0);
    tick();
    drive(3'b001, 2, 0, 0);
    chk("str_rdy0", 64'(req_ready[0]), 64'h1);
    cdb("str0", 1'b0, 0, 0);
    tick();
    cdb("str1", 1'b1, 1, 0);
    chk("str_rdy1", 64'(req_ready[0]), 64'h1);
    drive(3'b001, 3, 0, 0);
    tick();
    cdb("str2", 1'b1, 2, 0);
    chk("str_rdy2", 64'(req_ready[0]), 64'h1);
    drive(3'b000, 0, 0, 0);
    tick();
    cdb("str3", 1'b1, 3, 0);
    tick();
    cdb("str4", 1'b0, 0, 0);
    chk("str_ptr", 64'(dut.rr_ptr), 64'h1);

    // reset mid-stream with all buffers full
    drive(3'b111, 5, 6, 7);
    tick();
    drive(3'b111, 5, 6, 7);
    tick();
    chk("pre_rst_hb", 64'(dut.hb_valid), 64'h7);
    chk("pre_rst_v", 64'(cdb_valid), 64'h1);
    rst_in_n = 1'b0;
    #1;
    chk("mrst_v", 64'(cdb_valid), 64'h0);
    chk("mrst_tag", 64'(cdb_tag), 64'h0);
    chk("mrst_val", 64'(cdb_val), 64'h0);
    chk("mrst_src", 64'(cdb_src), 64'h0);
    chk("mrst_rdy", 64'(req_ready), 64'h0);
    chk("mrst_hb", 64'(dut.hb_valid), 64'h0);
    drive(3'b000, 0, 0, 0);
    tick();
    rst_in_n = 1'b1;
    #1;
    chk("mrel_rdy", 64'(req_ready), 64'h7);
    chk("mrel_ptr", 64'(dut.rr_ptr), 64'h0);

    // three-way contention
    drive(3'b111, 5, 6, 7);
    tick();
    drive(3'b000, 0, 0, 0);
    tick();
    cdb("rr0", 1'b1, 5, 0);
    tick();
    cdb("rr1", 1'b1, 6, 1);
    tick();
    cdb("rr2", 1'b1, 7, 2);
    tick();
    cdb("rr3", 1'b0, 0, 0);
    drive(3'b101, 10, 0, 11);
    tick();
    drive(3'b000, 0, 0, 0);
    tick();
    cdb("rr4", 1'b1, 10, 0);
    tick();
    cdb("rr5", 1'b1, 11, 2);
    tick();
    cdb("rr6", 1'b0, 0, 0);
    chk("rr_ptr", 64'(dut.rr_ptr), 64'h0);

    // tag 0 drop
    drive(3'b011, 9, 0, 0);
    tick();
    drive(3'b000, 0, 0, 0);
    tick();
    cdb("t0_a", 1'b1, 9, 0);
    chk("t0_hb", 64'(dut.hb_valid), 64'h0);
    chk("t0_ptr", 64'(dut.rr_ptr), 64'h1);
    tick();
    cdb("t0_b", 1'b0, 0, 0);

    // flush
    drive(3'b010, 0, 2, 0);
    tick();
    drive(3'b101, 3, 0, 4);
    tick();
    cdb("fl_pre", 1'b1, 2, 1);
    chk("fl_hb", 64'(dut.hb_valid), 64'h5);
    drive(3'b000, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("fl_rdy", 64'(req_ready), 64'h0);
    tick();
    flush = 1'b0;
    cdb("fl_0", 1'b0, 0, 0);
    chk("fl_hb0", 64'(dut.hb_valid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cdb("fl_n", 1'b0, 0, 0);
    end
    chk("fl_ptr", 64'(dut.rr_ptr), 64'h2);

    // stall
    drive(3'b111, 12, 13, 8);
    tick();
    drive(3'b000, 0, 0, 0);
    tick();
    cdb("st_pre", 1'b1, 8, 2);
    rdy_in = 1'b0;
    #1;
    chk("st_rdy", 64'(req_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cdb("st_hold", 1'b1, 8, 2);
      chk("st_rdyh", 64'(req_ready), 64'h0);
      chk("st_hb", 64'(dut.hb_valid), 64'h3);
    end
    rdy_in = 1'b1;
    tick();
    cdb("st_r0", 1'b1, 12, 0);
    tick();
    cdb("st_r1", 1'b1, 13, 1);
    tick();
    cdb("st_r2", 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
